// File: rtl/mem_stage.sv
// RV32I memory stage: issues data-memory requests, aligns/extends loads, stalls upstream while waiting.
// Optional macro MEM_STAGE_MONITOR_EN fills the RVFI memory fields of mem_wb_reg.
package mem_stage_pkg;

    typedef struct packed {
        logic        commit;
        logic [63:0] order;
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] pc_next;
        logic [4:0]  rs1_s;
        logic [4:0]  rs2_s;
        logic [31:0] rs1_v;
        logic [31:0] rs2_v;
        logic [4:0]  rd_s;
        logic        regf_we;
        logic [31:0] alu_out;
        logic        mem_read;
        logic        mem_write;
        logic [2:0]  funct3;
    } ex_mem_reg_t;

    typedef struct packed {
        logic        commit;
        logic [63:0] order;
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] pc_next;
        logic [4:0]  rs1_s;
        logic [4:0]  rs2_s;
        logic [31:0] rs1_v;
        logic [31:0] rs2_v;
        logic [4:0]  rd_s;
        logic        regf_we;
        logic [31:0] rd_v;
        logic [31:0] mem_addr;
        logic [3:0]  mem_rmask;
        logic [3:0]  mem_wmask;
        logic [31:0] mem_rdata;
        logic [31:0] mem_wdata;
    } mem_wb_reg_t;

endpackage

module mem_stage
    import mem_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  ex_mem_reg_t ex_mem_reg,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_rmask,
    output logic [3:0]  dmem_wmask,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_resp,
    output logic        mem_stall,
    output mem_wb_reg_t mem_wb_reg
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    logic [0:0]  r_state;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;

    logic        w_memOp;
    logic [1:0]  w_a;
    logic        w_aligned;
    logic [3:0]  w_mask;
    logic        w_issue;
    logic        w_respDone;
    logic [31:0] w_reqAddr;
    logic [31:0] w_reqWdata;
    logic [31:0] w_raw;
    logic [31:0] w_loadData;
    mem_wb_reg_t w_next;

    assign w_memOp    = ex_mem_reg.commit & (ex_mem_reg.mem_read | ex_mem_reg.mem_write);
    assign w_a        = ex_mem_reg.alu_out[1:0];
    assign w_reqAddr  = {ex_mem_reg.alu_out[31:2], 2'b00};
    assign w_reqWdata = ex_mem_reg.rs2_v << {w_a, 3'b000};

    // funct3[1:0] encodes access size; the reserved size 2'b11 is never issued.
    always_comb begin
        w_mask    = 4'b0000;
        w_aligned = 1'b0;
        case (ex_mem_reg.funct3[1:0])
            2'b00: begin
                w_mask    = 4'b0001 << w_a;
                w_aligned = 1'b1;
            end
            2'b01: begin
                w_mask    = 4'b0011 << w_a;
                w_aligned = ~w_a[0];
            end
            2'b10: begin
                w_mask    = 4'b1111;
                w_aligned = (w_a == 2'b00);
            end
            default: begin
                w_mask    = 4'b0000;
                w_aligned = 1'b0;
            end
        endcase
    end

    // Reset gates the issue term so the request outputs drop the moment rst rises.
    assign w_issue    = (r_state == S_IDLE) & w_memOp & w_aligned & ~rst;
    assign w_respDone = (r_state == S_WAIT) & dmem_resp;
    assign mem_stall  = w_issue | ((r_state == S_WAIT) & ~dmem_resp);

    assign dmem_rmask = (w_issue & ex_mem_reg.mem_read)  ? w_mask : 4'b0000;
    assign dmem_wmask = (w_issue & ex_mem_reg.mem_write) ? w_mask : 4'b0000;
    assign dmem_addr  = w_issue ? w_reqAddr  : ((r_state == S_WAIT) ? r_addr  : 32'h0);
    assign dmem_wdata = w_issue ? w_reqWdata : ((r_state == S_WAIT) ? r_wdata : 32'h0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_addr  <= 32'h0;
            r_wdata <= 32'h0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_issue) begin
                        r_state <= S_WAIT;
                        r_addr  <= w_reqAddr;
                        r_wdata <= w_reqWdata;
                    end
                end
                S_WAIT: begin
                    if (dmem_resp) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef MEM_STAGE_MONITOR_EN
    logic [3:0] r_rmask;
    logic [3:0] r_wmask;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rmask <= 4'b0000;
            r_wmask <= 4'b0000;
        end else if (w_issue) begin
            r_rmask <= dmem_rmask;
            r_wmask <= dmem_wmask;
        end
    end
`endif

    // Load data is formatted in the response cycle; ex_mem_reg is still held by the stall.
    always_comb begin
        w_raw      = dmem_rdata >> {w_a, 3'b000};
        w_loadData = w_raw;
        case (ex_mem_reg.funct3)
            3'b000:  w_loadData = {{24{w_raw[7]}}, w_raw[7:0]};
            3'b001:  w_loadData = {{16{w_raw[15]}}, w_raw[15:0]};
            3'b100:  w_loadData = {24'h0, w_raw[7:0]};
            3'b101:  w_loadData = {16'h0, w_raw[15:0]};
            default: w_loadData = w_raw;
        endcase
    end

    always_comb begin
        w_next           = '0;
        w_next.commit    = ex_mem_reg.commit;
        w_next.order     = ex_mem_reg.order;
        w_next.inst      = ex_mem_reg.inst;
        w_next.pc        = ex_mem_reg.pc;
        w_next.pc_next   = ex_mem_reg.pc_next;
        w_next.rs1_s     = ex_mem_reg.rs1_s;
        w_next.rs2_s     = ex_mem_reg.rs2_s;
        w_next.rs1_v     = ex_mem_reg.rs1_v;
        w_next.rs2_v     = ex_mem_reg.rs2_v;
        w_next.rd_s      = ex_mem_reg.rd_s;
        w_next.regf_we   = ex_mem_reg.regf_we;
        if (w_memOp & ~w_aligned) begin
            w_next.rd_v = 32'h0;
        end else if (w_respDone & ex_mem_reg.mem_read) begin
            w_next.rd_v = w_loadData;
        end else begin
            w_next.rd_v = ex_mem_reg.alu_out;
        end
`ifdef MEM_STAGE_MONITOR_EN
        if (w_respDone) begin
            w_next.mem_addr  = r_addr;
            w_next.mem_rmask = r_rmask;
            w_next.mem_wmask = r_wmask;
            w_next.mem_rdata = dmem_rdata;
            w_next.mem_wdata = r_wdata;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_wb_reg <= '0;
        end else if (mem_stall) begin
            mem_wb_reg <= '0;
        end else begin
            mem_wb_reg <= w_next;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Randomized scoreboard bench for mem_stage; define MEM_STAGE_MONITOR_EN to also check the RVFI memory fields.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    ex_mem_reg_t exMem;
    logic [31:0] dmemAddr;
    logic [3:0]  dmemRmask;
    logic [3:0]  dmemWmask;
    logic [31:0] dmemWdata;
    logic [31:0] dmemRdata;
    logic        dmemResp;
    logic        memStall;
    mem_wb_reg_t memWb;

    int          nChecks = 0;
    int          nPass   = 0;
    mem_wb_reg_t expQ[$];
    mem_wb_reg_t monExp;
    logic [63:0] orderCtr = 64'd100;

    mem_stage dut (
        .clk        (clk),
        .rst        (rst),
        .ex_mem_reg (exMem),
        .dmem_addr  (dmemAddr),
        .dmem_rmask (dmemRmask),
        .dmem_wmask (dmemWmask),
        .dmem_wdata (dmemWdata),
        .dmem_rdata (dmemRdata),
        .dmem_resp  (dmemResp),
        .mem_stall  (memStall),
        .mem_wb_reg (memWb)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [511:0] act, input logic [511:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Reference model: access size in bytes, byte lanes touched, and load result.
    function automatic int sizeOf(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic [3:0] laneMask(input logic [2:0] f3, input logic [31:0] addr);
        int m;
        m = ((1 << sizeOf(f3)) - 1) << (addr % 4);
        return m[3:0];
    endfunction

    function automatic logic [31:0] loadValue(input logic [2:0] f3, input logic [31:0] addr,
                                              input logic [31:0] rdata);
        int          sz;
        logic [31:0] v;
        sz = sizeOf(f3);
        v  = rdata >> (8 * (addr % 4));
        if (sz < 4) begin
            v = v % (32'h1 << (8 * sz));
            if (!f3[2] && v[8*sz-1]) v = v | ~((32'h1 << (8 * sz)) - 32'h1);
        end
        return v;
    endfunction

    function automatic ex_mem_reg_t makeInstr(input logic [63:0] ord, input bit rd, input bit wr,
                                              input logic [2:0] f3, input logic [31:0] alu,
                                              input logic [31:0] rs2);
        ex_mem_reg_t e;
        e           = '0;
        e.commit    = 1'b1;
        e.order     = ord;
        e.inst      = $urandom;
        e.pc        = 32'h0000_4000 + ord[31:0] * 4;
        e.pc_next   = e.pc + 4;
        e.rs1_s     = 5'($urandom_range(0, 31));
        e.rs2_s     = 5'($urandom_range(0, 31));
        e.rs1_v     = $urandom;
        e.rs2_v     = rs2;
        e.rd_s      = 5'($urandom_range(0, 31));
        e.regf_we   = ~wr;
        e.alu_out   = alu;
        e.mem_read  = rd;
        e.mem_write = wr;
        e.funct3    = f3;
        return e;
    endfunction

    // Presents one instruction, plays the memory for it, and queues its expected retirement.
    task automatic applyStimulus(input ex_mem_reg_t ex, input int lat, input logic [31:0] rdata);
        mem_wb_reg_t exp;
        bit          isMem;
        bit          aligned;
        logic [31:0] expAddr;
        logic [31:0] expWdata;
        logic [3:0]  m;
        @(posedge clk); #1;
        exMem    = ex;
        dmemResp = 1'b0;
        isMem    = ex.commit && (ex.mem_read || ex.mem_write);
        aligned  = (ex.alu_out % sizeOf(ex.funct3)) == 0;
        exp         = '0;
        exp.commit  = ex.commit;  exp.order   = ex.order;   exp.inst  = ex.inst;
        exp.pc      = ex.pc;      exp.pc_next = ex.pc_next; exp.rs1_s = ex.rs1_s;
        exp.rs2_s   = ex.rs2_s;   exp.rs1_v   = ex.rs1_v;   exp.rs2_v = ex.rs2_v;
        exp.rd_s    = ex.rd_s;    exp.regf_we = ex.regf_we;
        if (!(isMem && aligned)) begin
            exp.rd_v = isMem ? 32'h0 : ex.alu_out;
            expQ.push_back(exp);
            @(negedge clk);
            checkOutput("stall_passthru", memStall, 1'b0);
            checkOutput("masks_passthru", {dmemRmask, dmemWmask}, 8'h00);
        end else begin
            expAddr  = ex.alu_out - (ex.alu_out % 4);
            expWdata = ex.rs2_v * (32'h1 << (8 * (ex.alu_out % 4)));
            m        = laneMask(ex.funct3, ex.alu_out);
            @(negedge clk);
            checkOutput("stall_issue", memStall, 1'b1);
            checkOutput("rmask_issue", dmemRmask, ex.mem_read ? m : 4'h0);
            checkOutput("wmask_issue", dmemWmask, ex.mem_write ? m : 4'h0);
            checkOutput("addr_issue", dmemAddr, expAddr);
            checkOutput("wdata_issue", dmemWdata, expWdata);
            for (int i = 1; i < lat; i++) begin
                @(posedge clk); #1;
                @(negedge clk);
                checkOutput("stall_wait", memStall, 1'b1);
                checkOutput("masks_wait", {dmemRmask, dmemWmask}, 8'h00);
                checkOutput("addr_held", dmemAddr, expAddr);
                checkOutput("wdata_held", dmemWdata, expWdata);
            end
            @(posedge clk); #1;
            dmemResp  = 1'b1;
            dmemRdata = rdata;
            exp.rd_v  = ex.mem_read ? loadValue(ex.funct3, ex.alu_out, rdata) : ex.alu_out;
`ifdef MEM_STAGE_MONITOR_EN
            exp.mem_addr  = expAddr;
            exp.mem_rmask = ex.mem_read ? m : 4'h0;
            exp.mem_wmask = ex.mem_write ? m : 4'h0;
            exp.mem_rdata = rdata;
            exp.mem_wdata = expWdata;
`endif
            expQ.push_back(exp);
            @(negedge clk);
            checkOutput("stall_resp", memStall, 1'b0);
            checkOutput("addr_resp", dmemAddr, expAddr);
            checkOutput("masks_resp", {dmemRmask, dmemWmask}, 8'h00);
        end
    endtask

    // Monitor: every committed output must match the head of the queue; everything else is a zero bubble.
    always @(negedge clk) begin
        if (memWb.commit === 1'b1) begin
            checkOutput("retire_expected", expQ.size() != 0, 1'b1);
            if (expQ.size() != 0) begin
                monExp = expQ.pop_front();
                checkOutput("rd_v", memWb.rd_v, monExp.rd_v);
                checkOutput("order", memWb.order, monExp.order);
                checkOutput("mem_wb_fields", memWb, monExp);
            end
        end else begin
            checkOutput("bubble", memWb, '0);
        end
    end

    initial begin
        ex_mem_reg_t e;
        int          kind;
        logic [2:0]  f3;
        logic [2:0]  loadF3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

        rst       = 1'b1;
        exMem     = '0;
        dmemResp  = 1'b0;
        dmemRdata = 32'h0;
        #1;
        checkOutput("reset_stall", memStall, 1'b0);
        checkOutput("reset_outputs", {dmemAddr, dmemWdata, dmemRmask, dmemWmask}, '0);
        checkOutput("reset_mem_wb", memWb, '0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        $display("[TB] directed cases");
        applyStimulus(makeInstr(orderCtr++, 0, 0, 3'd0, 32'h0000_1234, $urandom), 1, 32'h0);
        applyStimulus(makeInstr(orderCtr++, 1, 0, 3'd0, 32'h0000_1003, $urandom), 2, 32'h80FF_FF00);
        applyStimulus(makeInstr(orderCtr++, 1, 0, 3'd4, 32'h0000_1003, $urandom), 2, 32'h80FF_FF00);
        applyStimulus(makeInstr(orderCtr++, 0, 1, 3'd1, 32'h0000_2002, 32'h0000_BEEF), 3, 32'h0);
        applyStimulus(makeInstr(orderCtr++, 1, 0, 3'd2, 32'h0000_3000, $urandom), 1, 32'hCAFE_F00D);
        applyStimulus(makeInstr(orderCtr++, 0, 1, 3'd2, 32'h0000_3004, 32'h1357_9BDF), 1, 32'h0);
        applyStimulus(makeInstr(orderCtr++, 1, 0, 3'd2, 32'h0000_1001, $urandom), 1, 32'h0);
        applyStimulus(makeInstr(orderCtr++, 1, 0, 3'd1, 32'h0000_1002, $urandom), 1, 32'h0000_8001);

        $display("[TB] reset during an outstanding load");
        @(posedge clk); #1;
        exMem    = makeInstr(orderCtr++, 1, 0, 3'd2, 32'h0000_5000, $urandom);
        dmemResp = 1'b0;
        @(negedge clk);
        checkOutput("stall_before_reset", memStall, 1'b1);
        @(posedge clk); #1;
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        checkOutput("midwait_reset_stall", memStall, 1'b0);
        checkOutput("midwait_reset_req", {dmemAddr, dmemWdata, dmemRmask, dmemWmask}, '0);
        checkOutput("midwait_reset_mem_wb", memWb, '0);
`ifdef MEM_STAGE_MONITOR_EN
        checkOutput("midwait_reset_rvfi_rmask", memWb.mem_rmask, 4'h0);
`endif
        exMem = '0;
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        dmemResp  = 1'b1;
        dmemRdata = 32'hDEAD_BEEF;
        @(negedge clk);
        checkOutput("stray_resp_stall", memStall, 1'b0);
        checkOutput("stray_resp_masks", {dmemRmask, dmemWmask}, 8'h00);
        @(posedge clk); #1 dmemResp = 1'b0;
        @(negedge clk);
        checkOutput("stray_resp_no_commit", memWb.commit, 1'b0);

        $display("[TB] randomized traffic");
        for (int n = 0; n < 300; n++) begin
            kind = $urandom_range(0, 2);
            if (kind == 0) begin
                f3 = 3'($urandom_range(0, 7));
                e  = makeInstr(orderCtr++, 0, 0, f3, $urandom, $urandom);
            end else if (kind == 1) begin
                f3 = loadF3[$urandom_range(0, 4)];
                e  = makeInstr(orderCtr++, 1, 0, f3, $urandom, $urandom);
            end else begin
                f3 = 3'($urandom_range(0, 2));
                e  = makeInstr(orderCtr++, 0, 1, f3, $urandom, $urandom);
            end
            applyStimulus(e, $urandom_range(1, 3), $urandom);
        end

        @(posedge clk); #1;
        exMem    = '0;
        dmemResp = 1'b0;
        for (int i = 0; i < 10 && expQ.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        checkOutput("queue_drained", expQ.size(), 0);
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
